ctrl_sequencer: RTL and testbench

- Multi-cycle control unit that sequences the 16-opcode ALU datapath: fetch, decode, execute, memory, writeback.
- Owns the 8-bit program counter (PC).
- Drives ALU select, register-file addresses and write enables, CMP flag-register load, and the data-memory handshake for LDR/STR.
- Sits between the instruction ROM, register file, ALU 16:1 result mux and data memory.

---
 rtl/ctrl_sequencer_if.sv | 46 ++++
 rtl/ctrl_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// Bus between ctrl_sequencer and its datapath: ROM fetch, decoded fields, strobes, data-memory handshake.
// The step input exists only when CTRL_SEQUENCER_STEP_EN is defined.
interface ctrl_sequencer_if #(
   parameter int PC_WIDTH = 8
);
   logic                run;
   logic [PC_WIDTH-1:0] instr_addr;
   logic [31:0]         instr_data;
   logic [3:0]          alu_sel;
   logic [3:0]          rd_addr;
   logic [3:0]          rs1_addr;
   logic [3:0]          rs2_addr;
   logic [15:0]         imm_out;
   logic [4:0]          shamt;
   logic                rf_we;
   logic                flag_we;
   logic                mem_req;
   logic                mem_we;
   logic                mem_ready;
   logic                busy;
`ifdef CTRL_SEQUENCER_STEP_EN
   logic                step;

   modport master (
      input  run, instr_data, mem_ready, step,
      output instr_addr, alu_sel, rd_addr, rs1_addr, rs2_addr, imm_out, shamt,
             rf_we, flag_we, mem_req, mem_we, busy
   );
   modport slave (
      output run, instr_data, mem_ready, step,
      input  instr_addr, alu_sel, rd_addr, rs1_addr, rs2_addr, imm_out, shamt,
             rf_we, flag_we, mem_req, mem_we, busy
   );
`else
   modport master (
      input  run, instr_data, mem_ready,
      output instr_addr, alu_sel, rd_addr, rs1_addr, rs2_addr, imm_out, shamt,
             rf_we, flag_we, mem_req, mem_we, busy
   );
   modport slave (
      output run, instr_data, mem_ready,
      input  instr_addr, alu_sel, rd_addr, rs1_addr, rs2_addr, imm_out, shamt,
             rf_we, flag_we, mem_req, mem_we, busy
   );
`endif
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer owning the PC for the 16-opcode ALU datapath.
// Optional single-step PAUSE after WRITEBACK when CTRL_SEQUENCER_STEP_EN is defined.
module ctrl_sequencer #(
   parameter int PC_WIDTH   = 8,
   parameter int MUL_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset,
   ctrl_sequencer_if.master bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_PAUSE  = 3'd6;

   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_CMP = 4'hB;
   localparam logic [3:0] OP_LDR = 4'hD;
   localparam logic [3:0] OP_STR = 4'hE;
   localparam logic [3:0] OP_NOP = 4'hF;

   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic [PC_WIDTH-1:0] r_pc;
   logic [31:0]         r_ir;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic                r_rf_we;
   logic                r_flag_we;
   logic                r_mem_req;
   logic                r_mem_we;
   logic                r_busy;
   logic [3:0]          w_op;
   logic                w_is_mem;
   logic                w_writes_rf;

   assign w_op        = r_ir[31:28];
   assign w_is_mem    = (w_op == OP_LDR) || (w_op == OP_STR);
   assign w_writes_rf = (w_op != OP_CMP) && (w_op != OP_STR) && (w_op != OP_NOP);

   // Next-state and EXECUTE down-counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.run) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FETCH: begin
            w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (w_op == OP_NOP) begin
               w_state_nxt = S_WB;
            end else begin
               w_state_nxt = S_EXEC;
               w_cnt_nxt   = (w_op == OP_MUL) ? MUL_LOAD : 4'd0;
            end
         end
         S_EXEC: begin
            if (r_cnt != 4'd0) begin
               w_state_nxt = S_EXEC;
               w_cnt_nxt   = r_cnt - 4'd1;
            end else if (w_is_mem) begin
               w_state_nxt = S_MEM;
            end else begin
               w_state_nxt = S_WB;
            end
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               w_state_nxt = S_WB;
            end else begin
               w_state_nxt = S_MEM;
            end
         end
         S_WB: begin
`ifdef CTRL_SEQUENCER_STEP_EN
            w_state_nxt = S_PAUSE;
`else
            if (bus.run) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
            end
`endif
         end
`ifdef CTRL_SEQUENCER_STEP_EN
         S_PAUSE: begin
            if (!bus.step) begin
               w_state_nxt = S_PAUSE;
            end else if (bus.run) begin
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State, PC, IR and strobes; strobes are registered from the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_pc      <= '0;
         r_ir      <= 32'd0;
         r_rf_we   <= 1'b0;
         r_flag_we <= 1'b0;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state == S_FETCH) begin
            r_ir <= bus.instr_data;
         end else begin
            r_ir <= r_ir;
         end
         if (r_state == S_WB) begin
            r_pc <= r_pc + PC_WIDTH'(1);
         end else begin
            r_pc <= r_pc;
         end
         r_rf_we   <= (w_state_nxt == S_WB) && w_writes_rf;
         r_flag_we <= (w_state_nxt == S_EXEC) && (w_cnt_nxt == 4'd0) && (w_op == OP_CMP);
         r_mem_req <= (w_state_nxt == S_MEM);
         r_mem_we  <= (w_state_nxt == S_MEM) && (w_op == OP_STR);
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign bus.instr_addr = r_pc;
   assign bus.alu_sel    = r_ir[31:28];
   assign bus.rd_addr    = r_ir[27:24];
   assign bus.rs1_addr   = r_ir[23:20];
   assign bus.rs2_addr   = r_ir[19:16];
   assign bus.imm_out    = r_ir[15:0];
   assign bus.shamt      = r_ir[4:0];
   assign bus.rf_we      = r_rf_we;
   assign bus.flag_we    = r_flag_we;
   assign bus.mem_req    = r_mem_req;
   assign bus.mem_we     = r_mem_we;
   assign bus.busy       = r_busy;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed vector table, corner sequences and a randomized
// program run against an instruction-level latency model.
module tb_ctrl_sequencer;
   localparam int MC = 3;

   typedef struct {
      logic [31:0] instr;
      int          wait_c;
      int          lat;
      int          rf_n;
      int          fl_n;
      int          mr_n;
      int          mw_n;
      int          rf_cyc;
   } vec_t;

   typedef struct {
      logic        busy;
      logic        rf;
      logic        fl;
      logic        mreq;
      logic        mwe;
      logic        mrdy;
      logic        fields;
      logic [7:0]  addr;
      logic [31:0] ir;
   } cyc_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] rom [0:255];
   int          checks = 0;
   int          failures = 0;

   ctrl_sequencer_if #(.PC_WIDTH(8)) bus ();

   ctrl_sequencer #(.PC_WIDTH(8), .MUL_CYCLES(MC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.instr_data = rom[bus.instr_addr];

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.run = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // One instruction from IDLE, run dropped after it starts; strobe counts compared to the table
   task automatic apply_vec(input vec_t v, input int idx);
      int   cyc = 0, rf_n = 0, fl_n = 0, mr_n = 0, mw_n = 0, rf_c = 0, ovl = 0;
      logic done = 1'b0;
      logic is_mem;
      logic [31:0] w;
      w = v.instr;
      is_mem = (w[31:28] == 4'hD) || (w[31:28] == 4'hE);
      do_reset();
      rom[0] = v.instr;
      bus.run = 1'b1;
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         bus.run = 1'b0;
         if (!bus.busy) begin
            done = 1'b1;
         end else begin
            if (bus.rf_we) begin rf_n++; rf_c = cyc; end
            if (bus.flag_we) fl_n++;
            if (bus.mem_req) mr_n++;
            if (bus.mem_req && bus.mem_we) mw_n++;
            if ((int'(bus.rf_we) + int'(bus.flag_we) + int'(bus.mem_req)) > 1) ovl++;
         end
         bus.mem_ready = is_mem ? (cyc == 4 + v.wait_c) : 1'b1;
      end
      chk($sformatf("vec%0d_done", idx), 64'(done), 64'd1);
      chk($sformatf("vec%0d_latency", idx), 64'(cyc - 1), 64'(v.lat));
      chk($sformatf("vec%0d_rf_pulses", idx), 64'(rf_n), 64'(v.rf_n));
      chk($sformatf("vec%0d_flag_pulses", idx), 64'(fl_n), 64'(v.fl_n));
      chk($sformatf("vec%0d_mem_req_cycles", idx), 64'(mr_n), 64'(v.mr_n));
      chk($sformatf("vec%0d_mem_we_cycles", idx), 64'(mw_n), 64'(v.mw_n));
      chk($sformatf("vec%0d_rf_cycle", idx), 64'(rf_c), 64'(v.rf_cyc));
      chk($sformatf("vec%0d_strobe_overlap", idx), 64'(ovl), 64'd0);
      chk($sformatf("vec%0d_pc_after", idx), 64'(bus.instr_addr), 64'd1);
   endtask

   // Runs rom[0..n-1] back to back from reset, comparing every cycle against the latency model
   task automatic run_trace(input int n, input string tag);
      cyc_t        q[$];
      cyc_t        c;
      int          lat, w, last_start;
      logic [3:0]  op;
      logic        mem;
      logic [31:0] word;
      last_start = 0;
      for (int i = 0; i < n; i++) begin
         word = rom[i];
         op   = word[31:28];
         mem  = (op == 4'hD) || (op == 4'hE);
         w    = mem ? int'($urandom_range(0, 3)) : 0;
         if (op == 4'hF)      lat = 3;
         else if (op == 4'h2) lat = 3 + MC;
         else if (mem)        lat = 5 + w;
         else                 lat = 4;
         last_start = q.size();
         for (int k = 1; k <= lat; k++) begin
            c.busy   = 1'b1;
            c.addr   = i[7:0];
            c.ir     = word;
            c.fields = (k >= 2);
            c.rf     = (k == lat) && !(op == 4'hB || op == 4'hE || op == 4'hF);
            c.fl     = (op == 4'hB) && (k == lat - 1);
            c.mreq   = mem && (k >= 4) && (k <= 4 + w);
            c.mwe    = c.mreq && (op == 4'hE);
            c.mrdy   = c.mreq ? (k == 4 + w) : 1'($urandom_range(0, 1));
            q.push_back(c);
         end
      end
      do_reset();
      bus.run = 1'b1;
      for (int k = 0; k < q.size(); k++) begin
         @(posedge clk); #1;
         if (k == last_start) bus.run = 1'b0;
         bus.mem_ready = q[k].mrdy;
         chk($sformatf("%s_cyc%0d_ctrl", tag, k),
             64'({bus.busy, bus.rf_we, bus.flag_we, bus.mem_req, bus.instr_addr}),
             64'({q[k].busy, q[k].rf, q[k].fl, q[k].mreq, q[k].addr}));
         if (q[k].mreq) begin
            chk($sformatf("%s_cyc%0d_mem_we", tag, k), 64'(bus.mem_we), 64'(q[k].mwe));
         end
         if (q[k].fields) begin
            chk($sformatf("%s_cyc%0d_fields", tag, k),
                64'({bus.alu_sel, bus.rd_addr, bus.rs1_addr, bus.rs2_addr, bus.imm_out, bus.shamt}),
                64'({q[k].ir[31:16], q[k].ir[15:0], q[k].ir[4:0]}));
         end
      end
      @(posedge clk); #1;
      chk({tag, "_parked_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_parked_pc"}, 64'(bus.instr_addr), 64'(n % 256));
   endtask

   initial begin
      vec_t vecs[10];
      int   rf_seen;
`ifdef CTRL_SEQUENCER_STEP_EN
      bus.step = 1'b0;
`endif
      bus.run = 1'b0;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 32'hF000_0000;

      //        instr          wait lat rf fl mr mw rfcyc
      vecs[0] = '{32'h0123_0000, 0, 4, 1, 0, 0, 0, 4};
      vecs[1] = '{32'h2456_0000, 0, 6, 1, 0, 0, 0, 6};
      vecs[2] = '{32'hB120_0000, 0, 4, 0, 1, 0, 0, 0};
      vecs[3] = '{32'hF000_0000, 0, 3, 0, 0, 0, 0, 0};
      vecs[4] = '{32'hD300_0010, 2, 7, 1, 0, 3, 0, 7};
      vecs[5] = '{32'hE300_0010, 0, 5, 0, 0, 1, 1, 0};
      vecs[6] = '{32'h7ABC_0005, 0, 4, 1, 0, 0, 0, 4};
      vecs[7] = '{32'hC100_0000, 0, 4, 1, 0, 0, 0, 4};
      vecs[8] = '{32'hD400_0020, 0, 5, 1, 0, 1, 0, 5};
      vecs[9] = '{32'hE500_0030, 3, 8, 0, 0, 4, 4, 0};

      repeat (2) @(posedge clk); #1;
      chk("reset_outputs",
          64'({bus.busy, bus.rf_we, bus.flag_we, bus.mem_req, bus.mem_we, bus.instr_addr,
               bus.alu_sel, bus.rd_addr, bus.rs1_addr, bus.rs2_addr, bus.imm_out, bus.shamt}),
          64'd0);

      for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

      // Reset in the middle of a stalled load
      do_reset();
      rom[0] = 32'hD300_0010;
      bus.run = 1'b1;
      repeat (5) @(posedge clk); #1;
      chk("midmem_req_before_reset", 64'(bus.mem_req), 64'd1);
      bus.run = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("midmem_async_clear", 64'({bus.mem_req, bus.busy, bus.rf_we, bus.flag_we, bus.instr_addr}), 64'd0);
      rf_seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.rf_we || bus.flag_we) rf_seen++;
      end
      reset = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (bus.rf_we || bus.flag_we) rf_seen++;
      end
      chk("midmem_no_writeback", 64'(rf_seen), 64'd0);
      chk("midmem_idle", 64'({bus.busy, bus.instr_addr}), 64'd0);

      // CMP then NOP: one flag pulse, no rf_we, PC reaches 2
      rom[0] = 32'hB120_0000;
      rom[1] = 32'hF000_0000;
      run_trace(2, "cmpnop");

      // PC wrap over 256 NOPs with run dropped during the last one
      for (int i = 0; i < 256; i++) rom[i] = 32'hF000_0000;
      do_reset();
      bus.run = 1'b1;
      repeat (766) @(posedge clk); #1;
      chk("wrap_last_instr_pc", 64'({bus.busy, bus.instr_addr}), 64'h1FF);
      bus.run = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("wrap_parked", 64'({bus.busy, bus.instr_addr}), 64'd0);
      @(posedge clk); #1;
      chk("wrap_stays_idle", 64'({bus.busy, bus.instr_addr}), 64'd0);

      // Randomized programs
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 48; i++) rom[i] = $urandom();
         run_trace(48, $sformatf("rand%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
